// File: rtl/gate_ctrl_pkg.sv
// Shared encodings and defaults for the gated event-counter sequencer.
// Optional ARMED-state trigger timeout is enabled by defining GATE_CTRL_TIMEOUT_EN.
package gate_ctrl_pkg;

  localparam int unsigned GATE_CTRL_STATE_W         = 3;
  localparam int unsigned GATE_CTRL_WIDTH_DEF       = 128;
  localparam int unsigned GATE_CTRL_GATE_W_DEF      = 32;
  localparam int unsigned GATE_CTRL_TIMEOUT_CYC_DEF = 1000000;

  localparam logic [GATE_CTRL_STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [GATE_CTRL_STATE_W-1:0] ST_ARMED  = 3'd1;
  localparam logic [GATE_CTRL_STATE_W-1:0] ST_GATE   = 3'd2;
  localparam logic [GATE_CTRL_STATE_W-1:0] ST_SETTLE = 3'd3;
  localparam logic [GATE_CTRL_STATE_W-1:0] ST_DONE   = 3'd4;

  typedef enum logic [GATE_CTRL_STATE_W-1:0] {
    IDLE   = ST_IDLE,
    ARMED  = ST_ARMED,
    GATE   = ST_GATE,
    SETTLE = ST_SETTLE,
    DONE   = ST_DONE
  } gate_state_e;

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter; saturates at zero and flags the zero and last-count states.
// Used for the gate length and, with GATE_CTRL_TIMEOUT_EN, for the trigger wait.
module gate_timer
  import gate_ctrl_pkg::*;
#(
  parameter int unsigned W = GATE_CTRL_GATE_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);
  assign last = (count_q == W'(1));

endmodule

// File: rtl/gate_controller.sv
// Sequences an external counter as a gated event counter: arm, wait for trigger edge,
// open the gate for a latched length, capture the count. Timeout option: GATE_CTRL_TIMEOUT_EN.
module gate_controller
  import gate_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = GATE_CTRL_WIDTH_DEF,
  parameter int unsigned GATE_W      = GATE_CTRL_GATE_W_DEF,
  parameter int unsigned TIMEOUT_CYC = GATE_CTRL_TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              abort,
  input  logic [GATE_W-1:0] cfg_gate_len,
  input  logic              trig_in,
  input  logic              event_in,
  output logic              cnt_reset,
  output logic              cnt_enable,
  input  logic [WIDTH-1:0]  cnt_value,
  output logic [WIDTH-1:0]  result_data,
  output logic              result_timeout,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              busy
);

  gate_state_e      state_q, state_d;
  logic             gate_q, gate_d;
  logic             trig_q;
  logic             cnt_reset_q, cnt_reset_d;
  logic [WIDTH-1:0] result_data_q, result_data_d;
  logic             result_timeout_q, result_timeout_d;
  logic             result_valid_q, result_valid_d;
  logic             busy_q, busy_d;

  logic             trig_edge_c;
  logic             gt_load_c;
  logic             gt_en_c;
  logic             gt_zero;
  logic             gt_last;
  logic             tmo_expire_c;

  assign trig_edge_c = trig_in & ~trig_q;

  // The gate timer is loaded at arm, so it also serves as the latched gate length.
  gate_timer #(.W(GATE_W)) u_gate_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (gt_load_c),
    .load_val (cfg_gate_len),
    .en       (gt_en_c),
    .zero     (gt_zero),
    .last     (gt_last)
  );

`ifdef GATE_CTRL_TIMEOUT_EN
  logic tmo_zero;
  logic tmo_last;

  gate_timer #(.W(GATE_W)) u_tmo_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (gt_load_c),
    .load_val (GATE_W'(TIMEOUT_CYC)),
    .en       (state_q == ARMED),
    .zero     (tmo_zero),
    .last     (tmo_last)
  );

  assign tmo_expire_c = tmo_last | tmo_zero;
`else
  logic unused_tmo_c;

  assign unused_tmo_c = ^GATE_W'(TIMEOUT_CYC);
  assign tmo_expire_c = 1'b0;
`endif

  // Next-state and registered-output logic; abort overrides everything.
  always_comb begin
    state_d          = state_q;
    gate_d           = gate_q;
    cnt_reset_d      = 1'b0;
    result_data_d    = result_data_q;
    result_timeout_d = result_timeout_q;
    gt_load_c        = 1'b0;
    gt_en_c          = 1'b0;

    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d     = ARMED;
          cnt_reset_d = 1'b1;
          gt_load_c   = 1'b1;
        end
      end
      ARMED: begin
        if (trig_edge_c) begin
          if (gt_zero) begin
            state_d = SETTLE;
          end else begin
            state_d = GATE;
            gate_d  = 1'b1;
          end
        end else if (tmo_expire_c) begin
          state_d          = DONE;
          result_data_d    = '0;
          result_timeout_d = 1'b1;
        end
      end
      GATE: begin
        gt_en_c = 1'b1;
        if (gt_last) begin
          state_d = SETTLE;
          gate_d  = 1'b0;
        end
      end
      SETTLE: begin
        state_d          = DONE;
        result_data_d    = cnt_value;
        result_timeout_d = 1'b0;
      end
      DONE: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        gate_d  = 1'b0;
      end
    endcase

    if (abort) begin
      state_d          = IDLE;
      gate_d           = 1'b0;
      cnt_reset_d      = 1'b0;
      result_data_d    = result_data_q;
      result_timeout_d = result_timeout_q;
      gt_load_c        = 1'b0;
      gt_en_c          = 1'b0;
    end

    result_valid_d = (state_d == DONE);
    busy_d         = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      gate_q           <= 1'b0;
      trig_q           <= 1'b0;
      cnt_reset_q      <= 1'b0;
      result_data_q    <= '0;
      result_timeout_q <= 1'b0;
      result_valid_q   <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      gate_q           <= gate_d;
      trig_q           <= trig_in;
      cnt_reset_q      <= cnt_reset_d;
      result_data_q    <= result_data_d;
      result_timeout_q <= result_timeout_d;
      result_valid_q   <= result_valid_d;
      busy_q           <= busy_d;
    end
  end

  // Events pass straight through while the registered gate is open; abort closes it at once.
  assign cnt_enable     = event_in & gate_q & ~abort;
  assign cnt_reset      = cnt_reset_q;
  assign result_data    = result_data_q;
  assign result_timeout = result_timeout_q;
  assign result_valid   = result_valid_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_gate_controller.sv
// Bench for gate_controller with a behavioural counter and a per-cycle reference model.
// Timeout scenario runs only when GATE_CTRL_TIMEOUT_EN is defined.
module tb_gate_controller;

  localparam int unsigned WIDTH  = 128;
  localparam int unsigned GATE_W = 32;
  localparam int unsigned TMO    = 100;
`ifdef GATE_CTRL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              arm;
  logic              abort;
  logic [GATE_W-1:0] cfg_gate_len;
  logic              trig_in;
  logic              event_in;
  logic              cnt_reset;
  logic              cnt_enable;
  logic [WIDTH-1:0]  cnt_value;
  logic [WIDTH-1:0]  result_data;
  logic              result_timeout;
  logic              result_valid;
  logic              result_ready;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;
  int rst_seen = 0;

  gate_controller #(.WIDTH(WIDTH), .GATE_W(GATE_W), .TIMEOUT_CYC(TMO)) dut (
    .clk            (clk),
    .reset          (reset),
    .arm            (arm),
    .abort          (abort),
    .cfg_gate_len   (cfg_gate_len),
    .trig_in        (trig_in),
    .event_in       (event_in),
    .cnt_reset      (cnt_reset),
    .cnt_enable     (cnt_enable),
    .cnt_value      (cnt_value),
    .result_data    (result_data),
    .result_timeout (result_timeout),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple up-counter standing in for the external counter datapath.
  logic [WIDTH-1:0] ctr_q = '0;
  always @(posedge clk) begin
    if (cnt_reset) ctr_q <= '0;
    else if (cnt_enable) ctr_q <= ctr_q + WIDTH'(1);
  end
  assign cnt_value = ctr_q;

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (cnt_reset) rst_seen <= rst_seen + 1;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Reference model: tracks the measurement phase by flags and cycle counts.
  bit              m_armed = 0, m_settle = 0, m_have = 0, m_rstp = 0, m_tprev = 0, m_rtmo = 0;
  int              m_gate_left = 0, m_len = 0, m_tmo = 0, m_ev = 0;
  logic [WIDTH-1:0] m_rdata = '0;

  initial forever begin
    bit e_busy, e_rst, e_en, e_val;
    bit rstp_n;
    @(negedge clk);
    e_busy = m_armed || (m_gate_left > 0) || m_settle || m_have;
    e_rst  = m_rstp;
    e_en   = (m_gate_left > 0) && event_in && !abort;
    e_val  = m_have;
    if (!reset) begin
      e_busy = 0; e_rst = 0; e_en = 0; e_val = 0;
    end
    chk("m_busy", 128'(busy), 128'(e_busy));
    chk("m_cnt_reset", 128'(cnt_reset), 128'(e_rst));
    chk("m_cnt_enable", 128'(cnt_enable), 128'(e_en));
    chk("m_result_valid", 128'(result_valid), 128'(e_val));
    if (e_val) begin
      chk("m_result_data", result_data, m_rdata);
      chk("m_result_timeout", 128'(result_timeout), 128'(m_rtmo));
    end

    if (!reset) begin
      m_armed = 0; m_settle = 0; m_have = 0; m_rstp = 0; m_rtmo = 0;
      m_gate_left = 0; m_rdata = '0;
    end else if (abort) begin
      m_armed = 0; m_settle = 0; m_have = 0; m_rstp = 0; m_gate_left = 0;
    end else begin
      rstp_n = 0;
      if (m_have) begin
        if (result_ready) m_have = 0;
      end else if (m_settle) begin
        m_settle = 0; m_have = 1; m_rdata = WIDTH'(m_ev); m_rtmo = 0;
      end else if (m_gate_left > 0) begin
        if (event_in) m_ev++;
        m_gate_left--;
        if (m_gate_left == 0) m_settle = 1;
      end else if (m_armed) begin
        if (trig_in && !m_tprev) begin
          m_armed = 0;
          if (m_len == 0) m_settle = 1;
          else m_gate_left = m_len;
        end else if (TMO_EN) begin
          m_tmo--;
          if (m_tmo == 0) begin
            m_armed = 0; m_have = 1; m_rdata = '0; m_rtmo = 1;
          end
        end
      end else if (arm) begin
        m_armed = 1; rstp_n = 1; m_len = int'(cfg_gate_len); m_tmo = int'(TMO); m_ev = 0;
      end
      m_rstp = rstp_n;
    end
    m_tprev = reset ? trig_in : 1'b0;
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns cycles from t0 to the first cycle with result_valid, or -1 on budget expiry.
  task automatic wait_valid(input int t0, output int lat);
    lat = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (result_valid) begin
        lat = cyc_n - t0;
        break;
      end
    end
  endtask

  initial begin
    int t, lat, r0;
    reset = 1'b0; arm = 1'b0; abort = 1'b0; cfg_gate_len = '0;
    trig_in = 1'b0; event_in = 1'b0; result_ready = 1'b0;
    cyc(3);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_valid", 128'(result_valid), 128'(0));
    chk("rst_data", result_data, 128'(0));
    reset = 1'b1;
    cyc(2);

    // len=10, events continuously, result held while ready low
    cfg_gate_len = 32'd10; arm = 1'b1; cyc(); arm = 1'b0; cyc(2);
    trig_in = 1'b1; event_in = 1'b1; t = cyc_n;
    wait_valid(t, lat);
    chk("t2_latency", 128'(lat), 128'(12));
    chk("t2_data", result_data, 128'(10));
    event_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t2_hold_valid", 128'(result_valid), 128'(1));
      chk("t2_hold_data", result_data, 128'(10));
    end
    result_ready = 1'b1; cyc(); result_ready = 1'b0; trig_in = 1'b0; cyc();
    chk("t2_valid_drop", 128'(result_valid), 128'(0));
    chk("t2_idle", 128'(busy), 128'(0));

    // len=20, events on gate cycles 1,4,7,... and beyond the gate
    r0 = rst_seen;
    cfg_gate_len = 32'd20; arm = 1'b1; cyc(); arm = 1'b0; cyc();
    trig_in = 1'b1; t = cyc_n; lat = -1;
    for (int i = 1; i <= 25; i++) begin
      cyc();
      event_in = ((i - 1) % 3) == 0;
      @(negedge clk);
      if (result_valid && lat < 0) lat = i;
    end
    chk("t3_latency", 128'(lat), 128'(22));
    chk("t3_data", result_data, 128'(7));
    chk("t3_rst_pulses", 128'(rst_seen - r0), 128'(1));
    event_in = 1'b0; trig_in = 1'b0; cyc();
    result_ready = 1'b1; cyc(); result_ready = 1'b0; cyc();

    // asynchronous reset in the middle of a gate
    cfg_gate_len = 32'd30; arm = 1'b1; cyc(); arm = 1'b0; cyc();
    trig_in = 1'b1; cyc(); event_in = 1'b1; cyc(4);
    chk("t1_pre_busy", 128'(busy), 128'(1));
    #2 reset = 1'b0;
    #1;
    chk("t1_busy", 128'(busy), 128'(0));
    chk("t1_cnt_enable", 128'(cnt_enable), 128'(0));
    chk("t1_cnt_reset", 128'(cnt_reset), 128'(0));
    chk("t1_valid", 128'(result_valid), 128'(0));
    chk("t1_data", result_data, 128'(0));
    chk("t1_timeout", 128'(result_timeout), 128'(0));
    @(posedge clk); #1;
    reset = 1'b1; event_in = 1'b0; trig_in = 1'b0;
    cyc(2);

    // len=0, trigger already high at arm needs a fresh edge
    trig_in = 1'b1; cyc(3);
    cfg_gate_len = 32'd0; arm = 1'b1; cyc(); arm = 1'b0; cyc(6);
    chk("t4_still_armed", 128'(busy), 128'(1));
    chk("t4_no_result", 128'(result_valid), 128'(0));
    trig_in = 1'b0; cyc();
    trig_in = 1'b1; t = cyc_n;
    wait_valid(t, lat);
    chk("t4_latency", 128'(lat), 128'(2));
    chk("t4_data", result_data, 128'(0));
    chk("t4_timeout", 128'(result_timeout), 128'(0));
    cyc(); result_ready = 1'b1; cyc(); result_ready = 1'b0; trig_in = 1'b0; cyc(2);

    // abort at gate cycle 5 of len=50; arm during gate ignored
    cfg_gate_len = 32'd50; arm = 1'b1; cyc(); arm = 1'b0; cyc();
    trig_in = 1'b1; cyc(2);
    arm = 1'b1; cfg_gate_len = 32'd3; cyc(); arm = 1'b0;
    chk("t5_arm_ignored_rst", 128'(cnt_reset), 128'(0));
    chk("t5_arm_ignored_busy", 128'(busy), 128'(1));
    cyc(2);
    event_in = 1'b1; abort = 1'b1; #1;
    chk("t5_abort_enable", 128'(cnt_enable), 128'(0));
    cyc(); abort = 1'b0; event_in = 1'b0;
    chk("t5_abort_idle", 128'(busy), 128'(0));
    cyc(60);
    chk("t5_no_result", 128'(result_valid), 128'(0));
    trig_in = 1'b0; cyc(2);

`ifdef GATE_CTRL_TIMEOUT_EN
    // no trigger: timeout result after TMO armed cycles
    cfg_gate_len = 32'd5; arm = 1'b1; t = cyc_n; cyc(); arm = 1'b0;
    wait_valid(t, lat);
    chk("t6_latency", 128'(lat), 128'(101));
    chk("t6_timeout", 128'(result_timeout), 128'(1));
    chk("t6_data", result_data, 128'(0));
    cyc(); result_ready = 1'b1; cyc(); result_ready = 1'b0; cyc(2);
    chk("t6_idle", 128'(busy), 128'(0));
`endif

    cyc(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
